// File: rtl/mips_defines.sv
// Shared definitions for the MIPS-32 front end: reset vector, decode redirect
// encodings, fetch FSM states, the IF/ID register layout and the bubble word.
package mips_defines;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

    // pcsrcD encodings coming back from decode: {jump, taken}
    localparam logic [1:0] PCSRC_NONE   = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // presenting pcF on the bus
        S_WAIT = 2'd1,  // request accepted, waiting for data_ok
        S_HOLD = 2'd2   // word received while decode stalled, parked in ibuf
    } fetch_state_e;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        valid;
        logic        adel;
    } ifid_t;

    // Jump wins over branch when decode raises both bits.
    function automatic logic [31:0] redirect_target(input logic [1:0]  pcsrc,
                                                    input logic [31:0] br_tgt,
                                                    input logic [31:0] jmp_tgt);
        return ((pcsrc & PCSRC_JUMP) != PCSRC_NONE) ? jmp_tgt : br_tgt;
    endfunction

endpackage

// File: rtl/flopenrc.sv
// Register with enable, synchronous clear (effective only when enabled) and
// asynchronous active-low reset. Used for the IF/ID fields.
module flopenrc #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // Hold unless enabled; an enabled clear loads all-zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     q_o <= '0;
        else if (en_i)   q_o <= clr_i ? '0 : d_i;
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, runs the single-outstanding instruction bus
// handshake and feeds the IF/ID register. Branch delay slots always execute,
// so a decode redirect only changes the fetch after the word at pcF.
module fetch_stage
    import mips_defines::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallD,
    input  logic        flush_exc,
    input  logic [31:0] newpc,
    input  logic [1:0]  pcsrcD,
    input  logic [31:0] pcbranchD,
    input  logic [31:0] pcjumpD,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pcplus4D,
    output logic        validD,
    output logic        adelD,
    output logic        fetch_stall
);

    fetch_state_e state_q;
    logic [31:0]  pcF_q, pend_pc_q, ibuf_q;
    logic         pend_valid_q, cancel_q;

    logic         misal, accept, avail, deliver, redir, outstanding;
    logic [31:0]  word, target, next_pc_d;
    ifid_t        ifid_d, ifid_q;
    logic         ifid_en, ifid_clr;

    assign misal     = (pcF_q[1:0] != 2'b00);
    // A misaligned PC never goes out on the bus; it is turned into an AdEL bubble.
    assign inst_req  = resetn & (state_q == S_REQ) & ~misal;
    assign inst_addr = pcF_q;
    assign accept    = inst_req & inst_addr_ok;

    // Is there something to hand to decode this cycle, and which word is it.
    always_comb begin
        avail = 1'b0;
        word  = NOP_WORD;
        case (state_q)
            S_REQ:   avail = misal;
            S_WAIT: begin
                avail = inst_data_ok & ~cancel_q;
                word  = inst_rdata;
            end
            S_HOLD: begin
                avail = 1'b1;
                word  = ibuf_q;
            end
            default: ;
        endcase
    end

    assign fetch_stall = ~avail;
    assign deliver     = avail & ~stallD & ~flush_exc;

    // Redirect is taken from the instruction sitting in decode, only when it advances.
    assign redir       = ~stallD & ~flush_exc & ifid_q.valid & (pcsrcD != PCSRC_NONE);
    assign target      = redirect_target(pcsrcD, pcbranchD, pcjumpD);
    assign next_pc_d   = redir        ? target    :
                         pend_valid_q ? pend_pc_q : pcF_q + 32'd4;
    // A response is still owed to us if we are waiting without data or get accepted now.
    assign outstanding = ((state_q == S_WAIT) & ~inst_data_ok) | accept;

    assign ifid_d = '{instr:   word,
                      pc:      pcF_q,
                      pcplus4: pcF_q + 32'd4,
                      valid:   1'b1,
                      adel:    (state_q == S_REQ) & misal};
    // Advance when decode advances (or on flush); anything not delivered becomes a bubble.
    assign ifid_en  = ~stallD | flush_exc;
    assign ifid_clr = flush_exc | ~deliver;

    // Fetch FSM, PC, pending redirect, cancel flag and hold buffer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_REQ;
            pcF_q        <= RESET_PC;
            cancel_q     <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            ibuf_q       <= '0;
        end else if (flush_exc) begin
            pcF_q        <= newpc;
            pend_valid_q <= 1'b0;
            if (outstanding) begin
                state_q  <= S_WAIT;
                cancel_q <= 1'b1;
            end else begin
                state_q  <= S_REQ;
                cancel_q <= 1'b0;
            end
        end else begin
            if (deliver) begin
                pcF_q        <= next_pc_d;
                pend_valid_q <= 1'b0;
            end else if (redir) begin
                // delay slot not delivered yet: remember where to go after it
                pend_valid_q <= 1'b1;
                pend_pc_q    <= target;
            end
            case (state_q)
                S_REQ:  if (accept) state_q <= S_WAIT;
                S_WAIT: if (inst_data_ok) begin
                    if (cancel_q) begin
                        cancel_q <= 1'b0;
                        state_q  <= S_REQ;
                    end else if (stallD) begin
                        ibuf_q   <= inst_rdata;
                        state_q  <= S_HOLD;
                    end else begin
                        state_q  <= S_REQ;
                    end
                end
                S_HOLD: if (!stallD) state_q <= S_REQ;
                default: state_q <= S_REQ;
            endcase
        end
    end

    flopenrc #(.WIDTH($bits(ifid_t))) u_ifid (
        .clk_i  (clk),
        .rst_ni (resetn),
        .en_i   (ifid_en),
        .clr_i  (ifid_clr),
        .d_i    (ifid_d),
        .q_o    (ifid_q)
    );

    assign instrD   = ifid_q.instr;
    assign pcD      = ifid_q.pc;
    assign pcplus4D = ifid_q.pcplus4;
    assign validD   = ifid_q.valid;
    assign adelD    = ifid_q.adel;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small single-outstanding bus responder.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        resetn, stallD, flush_exc;
    logic [31:0] newpc, pcbranchD, pcjumpD;
    logic [1:0]  pcsrcD;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic [31:0] instrD, pcD, pcplus4D;
    logic        validD, adelD, fetch_stall;

    int          tests = 0, fails = 0;
    bit          pending;
    logic [31:0] paddr, watch;
    int          cnt, lat, req_hits;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .resetn(resetn), .stallD(stallD), .flush_exc(flush_exc), .newpc(newpc),
        .pcsrcD(pcsrcD), .pcbranchD(pcbranchD), .pcjumpD(pcjumpD),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D), .validD(validD), .adelD(adelD),
        .fetch_stall(fetch_stall)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample bus at negedge, advance responder after posedge, settle.
    task automatic tick();
        logic        acc, dok;
        logic [31:0] aaddr;
        @(negedge clk);
        acc   = inst_req & inst_addr_ok;
        aaddr = inst_addr;
        dok   = inst_data_ok;
        if (inst_req && inst_addr == watch) req_hits++;
        @(posedge clk);
        #1;
        if (dok) pending = 1'b0;
        if (acc) begin
            pending = 1'b1;
            paddr   = aaddr;
            cnt     = lat;
        end else if (pending && cnt > 0) begin
            cnt--;
        end
        inst_data_ok = pending && (cnt == 0);
        inst_rdata   = inst_data_ok ? mem(paddr) : 32'hDEAD_BEEF;
        inst_addr_ok = ~pending;
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (validD !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, validD, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 0; stallD = 0; flush_exc = 0; newpc = 0;
        pcsrcD = 0; pcbranchD = 0; pcjumpD = 0;
        inst_addr_ok = 1; inst_data_ok = 0; inst_rdata = 0;
        pending = 0; paddr = 0; cnt = 0; lat = 0; watch = 32'hFFFF_FFFF; req_hits = 0;
        tick(); tick();

        // reset state
        chk("rst_req",   inst_req,  0);
        chk("rst_addr",  inst_addr, 32'hBFC0_0000);
        chk("rst_valid", validD,    0);
        chk("rst_instr", instrD,    0);
        chk("rst_pcD",   pcD,       0);
        chk("rst_pc4",   pcplus4D,  0);
        chk("rst_adel",  adelD,     0);

        // 1: sequential fetch, one delivery every second cycle
        resetn = 1;
        #1;
        chk("t1_req",    inst_req,  1);
        chk("t1_addr0",  inst_addr, 32'hBFC0_0000);
        tick();
        chk("t1_stall0", fetch_stall, 0);
        chk("t1_vld_b",  validD,    0);
        tick();
        chk("t1_vld0",   validD,    1);
        chk("t1_pcD0",   pcD,       32'hBFC0_0000);
        chk("t1_ins0",   instrD,    mem(32'hBFC0_0000));
        chk("t1_pc4_0",  pcplus4D,  32'hBFC0_0004);
        chk("t1_addr1",  inst_addr, 32'hBFC0_0004);
        tick();
        chk("t1_bubble", validD,    0);
        tick();
        chk("t1_vld1",   validD,    1);
        chk("t1_pcD1",   pcD,       32'hBFC0_0004);
        chk("t1_addr2",  inst_addr, 32'hBFC0_0008);
        repeat (6) tick();

        // 2: taken branch at BFC00010, delay slot BFC00014 kept
        chk("t2_pcD",    pcD,       32'hBFC0_0010);
        chk("t2_addr",   inst_addr, 32'hBFC0_0014);
        pcsrcD = 2'b01; pcbranchD = 32'hBFC0_0100;
        tick();
        pcsrcD = 2'b00;
        chk("t2_bubble", validD,    0);
        tick();
        chk("t2_slot",   pcD,       32'hBFC0_0014);
        chk("t2_vld",    validD,    1);
        chk("t2_target", inst_addr, 32'hBFC0_0100);

        // 3: decode stalled across the response, word parked and delivered once
        watch = 32'hBFC0_0100; req_hits = 0;
        stallD = 1;
        repeat (3) tick();
        chk("t3_hold_ins", instrD,   mem(32'hBFC0_0014));
        chk("t3_hold_pc",  pcD,      32'hBFC0_0014);
        chk("t3_noreq",    inst_req, 0);
        chk("t3_fstall",   fetch_stall, 0);
        stallD = 0; lat = 2;
        tick();
        chk("t3_pcD",    pcD,       32'hBFC0_0100);
        chk("t3_ins",    instrD,    mem(32'hBFC0_0100));
        chk("t3_vld",    validD,    1);
        chk("t3_once",   req_hits,  1);
        chk("t3_addr",   inst_addr, 32'hBFC0_0104);

        // 4: exception redirect while a slow response is outstanding
        tick();
        chk("t4_pre",    validD,    0);
        flush_exc = 1; newpc = 32'hBFC0_0380;
        tick();
        flush_exc = 0;
        chk("t4_fl_vld", validD,    0);
        chk("t4_fl_req", inst_req,  0);
        tick();
        chk("t4_stale",  fetch_stall, 1);
        lat = 0;
        tick();
        chk("t4_addr",   inst_addr, 32'hBFC0_0380);
        chk("t4_req",    inst_req,  1);
        chk("t4_vld0",   validD,    0);
        wait_valid("t4_wait");
        chk("t4_pcD",    pcD,       32'hBFC0_0380);
        chk("t4_ins",    instrD,    mem(32'hBFC0_0380));

        // 5: jr to a misaligned target -> AdEL bubble, no bus request
        pcsrcD = 2'b10; pcjumpD = 32'h0040_0002;
        watch = 32'h0040_0002; req_hits = 0;
        tick();
        pcsrcD = 2'b00;
        tick();
        chk("t5_slot",   pcD,       32'hBFC0_0384);
        chk("t5_noreq",  inst_req,  0);
        chk("t5_addr",   inst_addr, 32'h0040_0002);
        chk("t5_fstall", fetch_stall, 0);
        tick();
        chk("t5_ins",    instrD,    0);
        chk("t5_adel",   adelD,     1);
        chk("t5_vld",    validD,    1);
        chk("t5_pcD",    pcD,       32'h0040_0002);
        chk("t5_pc4",    pcplus4D,  32'h0040_0006);
        chk("t5_hits",   req_hits,  0);
        flush_exc = 1; newpc = 32'hBFC0_0200;
        tick();
        flush_exc = 0;
        chk("t5_rec_addr", inst_addr, 32'hBFC0_0200);
        chk("t5_rec_req",  inst_req,  1);
        chk("t5_rec_adel", adelD,     0);
        chk("t5_rec_vld",  validD,    0);

        // 6: exception and taken branch in the same cycle -> exception wins
        wait_valid("t6_wait0");
        chk("t6_pcD0",   pcD,       32'hBFC0_0200);
        pcsrcD = 2'b01; pcbranchD = 32'hBFC0_0800;
        flush_exc = 1; newpc = 32'hBFC0_0380;
        watch = 32'hBFC0_0800; req_hits = 0;
        tick();
        pcsrcD = 2'b00; flush_exc = 0;
        chk("t6_fl_vld", validD,    0);
        chk("t6_drop",   fetch_stall, 1);
        tick();
        chk("t6_addr",   inst_addr, 32'hBFC0_0380);
        wait_valid("t6_wait1");
        chk("t6_pcD1",   pcD,       32'hBFC0_0380);
        tick();
        wait_valid("t6_wait2");
        chk("t6_pcD2",   pcD,       32'hBFC0_0384);
        chk("t6_hits",   req_hits,  0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
